// File: rtl/lfsr_burst_ctrl_if.sv
// Command and PRBS output bundle for lfsr_burst_ctrl.
// The slave side is the controller; the master side issues commands and consumes words.
interface lfsr_burst_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [9:0] cmd_arg;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_data;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output cmd_valid, cmd_op, cmd_arg, out_ready,
      input  cmd_ready, out_valid, out_data, busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, out_ready,
      output cmd_ready, out_valid, out_data, busy, done, err
   );
endinterface

// File: rtl/lfsr_burst_ctrl.sv
// LFSR burst controller: emits bursts of words from a 10-bit Fibonacci LFSR
// (x^10 + x^7 + 1), one word per output handshake, under command control.
// The LFSR only moves on a handshake, so a stalled consumer always sees a stable word.
module lfsr_burst_ctrl (
   input  logic             clk,
   input  logic             rst,
   lfsr_burst_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_SEED  = 2'b01;
   localparam logic [1:0] OP_BURST = 2'b10;
   localparam logic [1:0] OP_ABORT = 2'b11;

   state_t     r_state;
   state_t     w_nextState;
   logic [9:0] r_lfsr;
   logic [9:0] w_nextLfsr;
   logic [9:0] r_count;
   logic [9:0] w_nextCount;
   logic       r_err;
   logic       w_nextErr;

   logic       w_cmdReady;
   logic       w_outValid;
   logic       w_cmdAccept;
   logic       w_handshake;
   logic       w_lastWord;
   logic [9:0] w_lfsrStep;

   assign w_lfsrStep  = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
   assign w_cmdReady  = (r_state != ST_DONE);
   assign w_outValid  = (r_state == ST_RUN);
   assign w_cmdAccept = bus.cmd_valid & w_cmdReady;
   assign w_handshake = w_outValid & bus.out_ready;
   assign w_lastWord  = w_handshake & (r_count == 10'd1);

   assign bus.cmd_ready = w_cmdReady;
   assign bus.out_valid = w_outValid;
   assign bus.out_data  = r_lfsr;
   assign bus.busy      = (r_state == ST_RUN);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.err       = r_err;

   // Next-state logic: command decode in IDLE, word accounting and abort/error handling in RUN.
   always_comb begin
      w_nextState = r_state;
      w_nextLfsr  = r_lfsr;
      w_nextCount = r_count;
      w_nextErr   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_cmdAccept) begin
               case (bus.cmd_op)
                  OP_SEED: begin
                     if (bus.cmd_arg != 10'd0) begin
                        w_nextLfsr = bus.cmd_arg;
                     end else begin
                        w_nextErr = 1'b1;
                     end
                  end
                  OP_BURST: begin
                     if (bus.cmd_arg != 10'd0) begin
                        w_nextCount = bus.cmd_arg;
                        w_nextState = ST_RUN;
                     end else begin
                        w_nextState = ST_DONE;
                     end
                  end
                  default: begin
                     w_nextState = ST_IDLE;
                  end
               endcase
            end
         end

         ST_RUN: begin
            if (w_handshake && (r_count != 10'd0)) begin
               w_nextLfsr  = w_lfsrStep;
               w_nextCount = r_count - 10'd1;
            end
            if (w_lastWord) begin
               w_nextState = ST_DONE;
            end
            if (w_cmdAccept) begin
               case (bus.cmd_op)
                  OP_ABORT: begin
                     if (!w_lastWord) begin
                        w_nextState = ST_IDLE;
                        w_nextCount = 10'd0;
                     end
                  end
                  OP_SEED, OP_BURST: begin
                     w_nextErr = 1'b1;
                  end
                  default: begin
                     w_nextErr = 1'b0;
                  end
               endcase
            end
         end

         ST_DONE: begin
            w_nextState = ST_IDLE;
         end

         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // State, LFSR, word counter and error pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_lfsr  <= 10'h001;
         r_count <= 10'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_lfsr  <= w_nextLfsr;
         r_count <= w_nextCount;
         r_err   <= w_nextErr;
      end
   end

endmodule
